i2c_target_regs: RTL

//  I2C target (responder) exposing a small byte register bank to an external board-management I2C master.

---
 rtl/i2c_target_regs.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_regs.sv
// I2C target with a byte register bank; reg 0 reads back temp_val, regs 1..NUM_REGS-1 are host-writable.
// Define I2C_GLITCH_FILTER_EN to add a FILT_LEN-cycle stability filter on the synchronised SCL/SDA.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h2A,
    parameter int          NUM_REGS = 8,
    parameter int          FILT_LEN = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        scl_in,
    input  logic                        sda_in,
    output logic                        sda_oe,
    input  logic [7:0]                  temp_val,
    output logic [8*NUM_REGS-1:0]       regs_out,
    output logic                        wr_strobe,
    output logic [$clog2(NUM_REGS)-1:0] wr_index,
    output logic                        busy
);
    localparam int PW = $clog2(NUM_REGS);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_IGNORE, S_ADDR_ACK, S_PTR,
        S_PTR_ACK, S_WRITE, S_WR_ACK, S_READ, S_RD_ACK
    } state_t;

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_lvl, sda_lvl;
    logic       scl_prev_q, sda_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    localparam int FCW = $clog2(FILT_LEN + 1);
    logic [FCW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
    logic           scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;

    // A new level is accepted only once it has been seen FILT_LEN cycles in a row.
    always_comb begin
        scl_cnt_d  = '0;
        scl_filt_d = scl_filt_q;
        if (scl_sync_q[1] != scl_filt_q) begin
            if (scl_cnt_q == FCW'(FILT_LEN - 1)) scl_filt_d = scl_sync_q[1];
            else                                 scl_cnt_d  = scl_cnt_q + 1'b1;
        end
        sda_cnt_d  = '0;
        sda_filt_d = sda_filt_q;
        if (sda_sync_q[1] != sda_filt_q) begin
            if (sda_cnt_q == FCW'(FILT_LEN - 1)) sda_filt_d = sda_sync_q[1];
            else                                 sda_cnt_d  = sda_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_cnt_q  <= scl_cnt_d;
            sda_cnt_q  <= sda_cnt_d;
            scl_filt_q <= scl_filt_d;
            sda_filt_q <= sda_filt_d;
        end
    end

    assign scl_lvl = scl_filt_q;
    assign sda_lvl = sda_filt_q;
`else
    assign scl_lvl = scl_sync_q[1];
    assign sda_lvl = sda_sync_q[1];
`endif

    state_t                  state_q, state_d;
    logic [7:0]              shift_q, shift_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic                    rw_q, rw_d;
    logic                    sda_oe_q, sda_oe_d;
    logic                    busy_q, busy_d;
    logic                    wr_strobe_q, wr_strobe_d;
    logic [PW-1:0]           wr_index_q, wr_index_d;
    logic [NUM_REGS-1:1][7:0] regs_q, regs_d;

    logic [NUM_REGS-1:0][7:0] img;
    logic [7:0] byte_in, rd_byte;
    logic scl_rise, scl_fall, start_det, stop_det, last_bit, addr_hit, ack_done;

    assign scl_rise  = scl_lvl & ~scl_prev_q;
    assign scl_fall  = ~scl_lvl & scl_prev_q;
    assign start_det = scl_lvl & scl_prev_q & sda_prev_q & ~sda_lvl;
    assign stop_det  = scl_lvl & scl_prev_q & ~sda_prev_q & sda_lvl;
    assign byte_in   = {shift_q[6:0], sda_lvl};
    assign last_bit  = scl_rise && (bit_cnt_q == 4'd7);
    assign addr_hit  = (byte_in[7:1] == DEV_ADDR);
    // Ack phases: bit_cnt[0]=0 waits for the fall that starts the ACK, =1 for the fall that ends it.
    assign ack_done  = scl_fall && bit_cnt_q[0];
    assign img       = {regs_q, temp_val};
    assign rd_byte   = img[ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
            regs_q      <= '0;
        end else begin
            state_q     <= state_d;
            scl_prev_q  <= scl_lvl;
            sda_prev_q  <= sda_lvl;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_index_q  <= wr_index_d;
            regs_q      <= regs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = S_ADDR;
        end else if (stop_det) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_ADDR:              if (last_bit) state_d = addr_hit ? S_ADDR_ACK : S_IGNORE;
                S_PTR:               if (last_bit) state_d = S_PTR_ACK;
                S_WRITE:             if (last_bit) state_d = S_WR_ACK;
                S_ADDR_ACK:          if (ack_done) state_d = rw_q ? S_READ : S_PTR;
                S_PTR_ACK, S_WR_ACK: if (ack_done) state_d = S_WRITE;
                S_READ:              if (scl_fall && bit_cnt_q == 4'd8) state_d = S_RD_ACK;
                S_RD_ACK: begin
                    if (scl_rise && sda_lvl) state_d = S_IGNORE;
                    else if (scl_fall)       state_d = S_READ;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_index_d  = wr_index_q;
        regs_d      = regs_q;
        if (start_det) begin
            bit_cnt_d = '0;
        end else if (stop_det) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WRITE: if (scl_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = last_bit ? 4'd0 : bit_cnt_q + 4'd1;
                    if (last_bit && state_q == S_ADDR && addr_hit) begin
                        busy_d = 1'b1;
                        rw_d   = sda_lvl;
                    end
                    if (last_bit && state_q == S_PTR) ptr_d = byte_in[PW-1:0];
                    if (last_bit && state_q == S_WRITE) begin
                        for (int i = 1; i < NUM_REGS; i++) begin
                            if (ptr_q == PW'(i)) begin
                                regs_d[i]   = byte_in;
                                wr_strobe_d = 1'b1;
                                wr_index_d  = ptr_q;
                            end
                        end
                        ptr_d = ptr_q + 1'b1;
                    end
                end
                S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: if (scl_fall) begin
                    if (!bit_cnt_q[0]) begin
                        sda_oe_d  = 1'b1;
                        bit_cnt_d = 4'd1;
                    end else begin
                        bit_cnt_d = '0;
                        if (state_q == S_ADDR_ACK && rw_q) begin
                            shift_d  = rd_byte;
                            sda_oe_d = ~rd_byte[7];
                        end else begin
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                S_READ: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        shift_d  = {shift_q[6:0], shift_q[7]};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        ptr_d = ptr_q + 1'b1;
                    end else if (scl_fall) begin
                        shift_d   = rd_byte;
                        sda_oe_d  = ~rd_byte[7];
                        bit_cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;
    assign regs_out  = img;

endmodule
